// File: rtl/rdi_pkg.sv
// rdi_pkg: shared definitions for the RDI bring-up arbiter.
//   - bring-up code constants (0 none .. 5 disable)
//   - bit positions of the pending request vector
//   - FSM state type and state constants
//   - fixed-priority encode and code-to-mask helpers
package rdi_pkg;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_ACTIVE    = 3'd1;
  localparam logic [2:0] CODE_RETRAIN   = 3'd2;
  localparam logic [2:0] CODE_LINKERROR = 3'd3;
  localparam logic [2:0] CODE_LINKRESET = 3'd4;
  localparam logic [2:0] CODE_DISABLE   = 3'd5;

  // pending vector layout: {disable, linkreset, linkerror, retrain, active}
  localparam int BIT_ACTIVE    = 0;
  localparam int BIT_RETRAIN   = 1;
  localparam int BIT_LINKERROR = 2;
  localparam int BIT_LINKRESET = 3;
  localparam int BIT_DISABLE   = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SERVE   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  // LINKERROR > LINKRESET > DISABLE > RETRAIN > ACTIVE
  function automatic logic [2:0] prio_code(input logic [4:0] p);
    logic [2:0] c;
    c = CODE_NONE;
    if (p[BIT_LINKERROR])      c = CODE_LINKERROR;
    else if (p[BIT_LINKRESET]) c = CODE_LINKRESET;
    else if (p[BIT_DISABLE])   c = CODE_DISABLE;
    else if (p[BIT_RETRAIN])   c = CODE_RETRAIN;
    else if (p[BIT_ACTIVE])    c = CODE_ACTIVE;
    return c;
  endfunction

  function automatic logic [4:0] code_mask(input logic [2:0] c);
    logic [4:0] m;
    m = 5'b00000;
    case (c)
      CODE_ACTIVE:    m[BIT_ACTIVE]    = 1'b1;
      CODE_RETRAIN:   m[BIT_RETRAIN]   = 1'b1;
      CODE_LINKERROR: m[BIT_LINKERROR] = 1'b1;
      CODE_LINKRESET: m[BIT_LINKRESET] = 1'b1;
      CODE_DISABLE:   m[BIT_DISABLE]   = 1'b1;
      default:        m = 5'b00000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rdi_bring_up_arbiter_if.sv
// rdi_bring_up_arbiter_if: request/handshake bundle between the RDI
// controller + general bring-up TX/RX pair (master) and the arbiter (slave).
//   i_req_*                           request pulses from the controller
//   i_General_Bring_Up_done_TX/RX     done levels from the bring-up blocks
//   o_rdi_controller_choosen_bring_up code in service
//   o_busy, o_pending                 arbiter status
//   o_complete, o_completed_code      completion pulse and last completed code
//   o_timeout                         timeout pulse
interface rdi_bring_up_arbiter_if;
  logic       i_req_active;
  logic       i_req_retrain;
  logic       i_req_linkerror;
  logic       i_req_linkreset;
  logic       i_req_disable;
  logic       i_General_Bring_Up_done_TX;
  logic       i_General_Bring_Up_done_RX;
  logic [2:0] o_rdi_controller_choosen_bring_up;
  logic       o_busy;
  logic [4:0] o_pending;
  logic       o_complete;
  logic [2:0] o_completed_code;
  logic       o_timeout;

  modport master (
    output i_req_active, i_req_retrain, i_req_linkerror, i_req_linkreset, i_req_disable,
    output i_General_Bring_Up_done_TX, i_General_Bring_Up_done_RX,
    input  o_rdi_controller_choosen_bring_up, o_busy, o_pending,
    input  o_complete, o_completed_code, o_timeout
  );

  modport slave (
    input  i_req_active, i_req_retrain, i_req_linkerror, i_req_linkreset, i_req_disable,
    input  i_General_Bring_Up_done_TX, i_General_Bring_Up_done_RX,
    output o_rdi_controller_choosen_bring_up, o_busy, o_pending,
    output o_complete, o_completed_code, o_timeout
  );
endinterface

// File: rtl/rdi_req_priority_enc.sv
// rdi_req_priority_enc: combinational fixed-priority encoder.
//   pending  in  5  latched requests {disable, linkreset, linkerror, retrain, active}
//   code     out 3  highest-priority bring-up code (0 when nothing pending)
//   clr_mask out 5  one-hot mask of the pending bit that code consumes
module rdi_req_priority_enc (
  input  logic [4:0] pending,
  output logic [2:0] code,
  output logic [4:0] clr_mask
);
  import rdi_pkg::*;

  assign code     = prio_code(pending);
  assign clr_mask = code_mask(code);
endmodule

// File: rtl/rdi_bring_up_arbiter.sv
// rdi_bring_up_arbiter: serializes RDI state-change requests by fixed
// priority, drives one bring-up code at a time to the TX/RX bring-up pair
// and waits for both dones, escalating to LINKERROR on timeout.
//   lclk     in  clock
//   sys_rst  in  asynchronous active-low reset
//   bus      slave side of rdi_bring_up_arbiter_if (requests, dones, status)
//
// state      | meaning
// IDLE       | no code driven; launch highest-priority pending request
// SERVE      | code held; collecting dones, counting toward timeout
// RELEASE    | code forced to 0 for one cycle so the TX block returns to idle
module rdi_bring_up_arbiter #(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 13
) (
  input logic                  lclk,
  input logic                  sys_rst,
  rdi_bring_up_arbiter_if.slave bus
);
  import rdi_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [2:0]       code_q;
  logic [2:0]       completed_q;
  logic [4:0]       pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stk_tx_q;
  logic             stk_rx_q;
  logic             busy_q;
  logic             complete_q;
  logic             timeout_q;

  logic [2:0] enc_code;
  logic [4:0] enc_clr;
  logic [4:0] req_vec;
  logic [4:0] pend_set;
  logic [4:0] pend_clr;
  logic       done_tx;
  logic       done_rx;
  logic       both_done;
  logic       at_limit;

  rdi_req_priority_enc u_enc (
    .pending  (pend_q),
    .code     (enc_code),
    .clr_mask (enc_clr)
  );

  assign req_vec = {bus.i_req_disable, bus.i_req_linkreset, bus.i_req_linkerror,
                    bus.i_req_retrain, bus.i_req_active};

  // Sticky flag OR the live input, so dones rising together (or split
  // across cycles) complete on the cycle the second one is seen.
  assign done_tx   = stk_tx_q | bus.i_General_Bring_Up_done_TX;
  assign done_rx   = stk_rx_q | bus.i_General_Bring_Up_done_RX;
  assign both_done = done_tx & done_rx;
  assign at_limit  = (cnt_q == CNT_LAST);

  always_comb begin
    pend_clr = 5'b00000;
    pend_set = req_vec;
    if (state_q == ST_IDLE) pend_clr = enc_clr;
    // A timed-out LINKERROR is not re-armed.
    if (state_q == ST_SERVE && !both_done && at_limit && code_q != CODE_LINKERROR)
      pend_set[BIT_LINKERROR] = 1'b1;
  end

  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_IDLE;
      code_q      <= CODE_NONE;
      completed_q <= CODE_NONE;
      pend_q      <= 5'b00000;
      cnt_q       <= '0;
      stk_tx_q    <= 1'b0;
      stk_rx_q    <= 1'b0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // set after clear: a request landing on its own issue cycle survives
      pend_q     <= (pend_q & ~pend_clr) | pend_set;
      complete_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|pend_q) begin
            state_q  <= ST_SERVE;
            code_q   <= enc_code;
            cnt_q    <= '0;
            stk_tx_q <= 1'b0;
            stk_rx_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ST_SERVE: begin
          stk_tx_q <= done_tx;
          stk_rx_q <= done_rx;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (both_done) begin
            complete_q  <= 1'b1;
            completed_q <= code_q;
            code_q      <= CODE_NONE;
            state_q     <= ST_RELEASE;
          end else if (at_limit) begin
            timeout_q <= 1'b1;
            code_q    <= CODE_NONE;
            state_q   <= ST_RELEASE;
          end else if (pend_q[BIT_LINKERROR] && code_q != CODE_LINKERROR) begin
            code_q  <= CODE_NONE;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          code_q  <= CODE_NONE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rdi_controller_choosen_bring_up = code_q;
  assign bus.o_busy           = busy_q;
  assign bus.o_pending        = pend_q;
  assign bus.o_complete       = complete_q;
  assign bus.o_completed_code = completed_q;
  assign bus.o_timeout        = timeout_q;
endmodule

// File: tb/tb_rdi_bring_up_arbiter.sv
// tb_rdi_bring_up_arbiter: directed bench for rdi_bring_up_arbiter with a
// short timeout (16 cycles). Inputs are driven and outputs sampled 1 time
// unit after each rising edge.
module tb_rdi_bring_up_arbiter;
  logic lclk = 1'b0;
  logic sys_rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  rdi_bring_up_arbiter_if bus();

  rdi_bring_up_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .lclk    (lclk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 lclk = ~lclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  // m = {disable, linkreset, linkerror, retrain, active}
  task automatic pulse(input logic [4:0] m);
    bus.i_req_active    = m[0];
    bus.i_req_retrain   = m[1];
    bus.i_req_linkerror = m[2];
    bus.i_req_linkreset = m[3];
    bus.i_req_disable   = m[4];
    tick();
    bus.i_req_active    = 1'b0;
    bus.i_req_retrain   = 1'b0;
    bus.i_req_linkerror = 1'b0;
    bus.i_req_linkreset = 1'b0;
    bus.i_req_disable   = 1'b0;
  endtask

  // Both dones for one cycle; ends in IDLE after the RELEASE cycle.
  task automatic serve_done(input string tag, input logic [2:0] exp_code);
    bus.i_General_Bring_Up_done_TX = 1'b1;
    bus.i_General_Bring_Up_done_RX = 1'b1;
    tick();
    bus.i_General_Bring_Up_done_TX = 1'b0;
    bus.i_General_Bring_Up_done_RX = 1'b0;
    chk({tag, "_complete"}, 32'(bus.o_complete), 32'd1);
    chk({tag, "_ccode"}, 32'(bus.o_completed_code), 32'(exp_code));
    chk({tag, "_rel_code"}, 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    tick();
    chk({tag, "_idle_code"}, 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    chk({tag, "_cmpl_drop"}, 32'(bus.o_complete), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_active = 0; bus.i_req_retrain = 0; bus.i_req_linkerror = 0;
    bus.i_req_linkreset = 0; bus.i_req_disable = 0;
    bus.i_General_Bring_Up_done_TX = 0; bus.i_General_Bring_Up_done_RX = 0;

    // reset values
    repeat (3) tick();
    chk("rst_code", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_pend", 32'(bus.o_pending), 32'd0);
    chk("rst_cmpl", 32'(bus.o_complete), 32'd0);
    chk("rst_ccode", 32'(bus.o_completed_code), 32'd0);
    chk("rst_tmo", 32'(bus.o_timeout), 32'd0);
    sys_rst = 1'b1;
    tick();

    // single request
    pulse(5'b00001);
    chk("s_pend", 32'(bus.o_pending), 32'h01);
    chk("s_code0", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    tick();
    chk("s_code", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd1);
    chk("s_busy", 32'(bus.o_busy), 32'd1);
    chk("s_pclr", 32'(bus.o_pending), 32'h00);
    repeat (5) tick();
    chk("s_hold", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd1);
    serve_done("s", 3'd1);
    chk("s_busy_end", 32'(bus.o_busy), 32'd0);

    // priority: retrain + active + disable together
    pulse(5'b10011);
    chk("p_pend0", 32'(bus.o_pending), 32'h13);
    tick();
    chk("p_code5", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd5);
    chk("p_pend1", 32'(bus.o_pending), 32'h03);
    serve_done("p5", 3'd5);
    tick();
    chk("p_code2", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd2);
    chk("p_pend2", 32'(bus.o_pending), 32'h01);
    serve_done("p2", 3'd2);
    tick();
    chk("p_code1", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd1);
    chk("p_pend3", 32'(bus.o_pending), 32'h00);
    serve_done("p1", 3'd1);
    tick();
    chk("p_busy_end", 32'(bus.o_busy), 32'd0);

    // split done: TX pulse early, RX later
    pulse(5'b00001);
    tick();
    repeat (2) tick();
    bus.i_General_Bring_Up_done_TX = 1'b1;
    tick();
    bus.i_General_Bring_Up_done_TX = 1'b0;
    chk("sd_no_cmpl0", 32'(bus.o_complete), 32'd0);
    repeat (6) tick();
    chk("sd_no_cmpl1", 32'(bus.o_complete), 32'd0);
    chk("sd_code", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd1);
    bus.i_General_Bring_Up_done_RX = 1'b1;
    tick();
    bus.i_General_Bring_Up_done_RX = 1'b0;
    chk("sd_cmpl", 32'(bus.o_complete), 32'd1);
    chk("sd_ccode", 32'(bus.o_completed_code), 32'd1);
    chk("sd_no_tmo", 32'(bus.o_timeout), 32'd0);
    repeat (2) tick();

    // timeout escalation
    pulse(5'b00010);
    tick();
    chk("t_code2", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd2);
    repeat (15) tick();
    chk("t_no_tmo15", 32'(bus.o_timeout), 32'd0);
    chk("t_hold15", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd2);
    tick();
    chk("t_tmo", 32'(bus.o_timeout), 32'd1);
    chk("t_rel_code", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    chk("t_le_armed", 32'(bus.o_pending), 32'h04);
    chk("t_no_cmpl", 32'(bus.o_complete), 32'd0);
    tick();
    chk("t_tmo_drop", 32'(bus.o_timeout), 32'd0);
    tick();
    chk("t_code3", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd3);
    chk("t_pend0", 32'(bus.o_pending), 32'h00);
    repeat (15) tick();
    chk("t2_no_tmo", 32'(bus.o_timeout), 32'd0);
    tick();
    chk("t2_tmo", 32'(bus.o_timeout), 32'd1);
    chk("t2_no_rearm", 32'(bus.o_pending), 32'h00);
    repeat (2) tick();
    chk("t2_idle_code", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    chk("t2_idle_busy", 32'(bus.o_busy), 32'd0);

    // preemption by linkerror during ACTIVE
    pulse(5'b00001);
    tick();
    repeat (2) tick();
    pulse(5'b00100);
    chk("pe_code1", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd1);
    chk("pe_pend", 32'(bus.o_pending), 32'h04);
    tick();
    chk("pe_rel_code", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    chk("pe_no_cmpl", 32'(bus.o_complete), 32'd0);
    chk("pe_no_tmo", 32'(bus.o_timeout), 32'd0);
    tick();
    tick();
    chk("pe_code3", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd3);
    serve_done("pe", 3'd3);
    tick();
    chk("pe_no_reissue", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    chk("pe_pend_end", 32'(bus.o_pending), 32'h00);
    chk("pe_busy_end", 32'(bus.o_busy), 32'd0);

    // asynchronous reset mid-SERVE
    pulse(5'b00011);
    tick();
    chk("r_code2", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd2);
    chk("r_pend", 32'(bus.o_pending), 32'h01);
    #2 sys_rst = 1'b0;
    #1;
    chk("r_code", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    chk("r_busy", 32'(bus.o_busy), 32'd0);
    chk("r_pclr", 32'(bus.o_pending), 32'h00);
    chk("r_ccode", 32'(bus.o_completed_code), 32'd0);
    tick();
    sys_rst = 1'b1;
    tick();
    chk("r_stay_idle", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd0);
    pulse(5'b10000);
    tick();
    chk("r_restart", 32'(bus.o_rdi_controller_choosen_bring_up), 32'd5);
    serve_done("r", 3'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
